// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with dead-time guard band.
// Optional leading-zero suppression is enabled by defining SEG7_SCAN_LZS_EN.
module seg7_scan_ctrl #(
  parameter int NDIGITS  = 4,
  parameter int AW       = 2,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [4:0]         wr_data,
  output logic [3:0]         nibble_out,
  output logic               blank_out,
  output logic [NDIGITS-1:0] digit_an_n,
  output logic               slot_start
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PW = $clog2(NDIGITS);

  logic [CW-1:0]             cnt, cnt_nx;
  logic [PW-1:0]             ptr, ptr_nx;
  logic [NDIGITS-1:0][4:0]   dig, dig_nx;
  logic [NDIGITS-1:0]        sup;
  logic [NDIGITS-1:0]        an_nx;
  logic                      eff_blank;
  logic                      dead_nx;
`ifdef SEG7_SCAN_LZS_EN
  logic                      above_empty;
`endif

  // Outputs are derived from next-state values so the registered pins
  // line up with the registered cnt/ptr/dig on every cycle.
  always_comb begin
    cnt_nx = cnt + 1'b1;
    ptr_nx = ptr;
    if (cnt == CW'(PRESCALE - 1)) begin
      cnt_nx = '0;
      ptr_nx = (ptr == PW'(NDIGITS - 1)) ? '0 : ptr + 1'b1;
    end

    dig_nx = dig;
    if (wr_en) begin
      for (int unsigned i = 0; i < NDIGITS; i++) begin
        if (wr_addr == AW'(i)) dig_nx[i] = wr_data;
      end
    end

    sup = '0;
`ifdef SEG7_SCAN_LZS_EN
    // Walk from the most significant digit down; digit 0 is never visited.
    above_empty = 1'b1;
    for (int unsigned i = NDIGITS - 1; i >= 1; i--) begin
      sup[i]      = (dig_nx[i][3:0] == 4'h0) && above_empty;
      above_empty = above_empty && ((dig_nx[i][3:0] == 4'h0) || dig_nx[i][4]);
    end
`endif

    eff_blank = dig_nx[ptr_nx][4] | sup[ptr_nx];
    dead_nx   = (cnt_nx < CW'(DEAD));

    an_nx = '1;
    if (!dead_nx && !eff_blank) begin
      for (int unsigned i = 0; i < NDIGITS; i++) begin
        if (ptr_nx == PW'(i)) an_nx[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      ptr        <= '0;
      for (int unsigned i = 0; i < NDIGITS; i++) dig[i] <= 5'h10;
      nibble_out <= '0;
      blank_out  <= 1'b1;
      digit_an_n <= '1;
      slot_start <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      ptr        <= ptr_nx;
      dig        <= dig_nx;
      nibble_out <= dig_nx[ptr_nx][3:0];
      blank_out  <= dead_nx | eff_blank;
      digit_an_n <= an_nx;
      slot_start <= (cnt_nx == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl against a cycle-index model.
// Define SEG7_SCAN_LZS_EN for both files to check leading-zero suppression.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int AW = 3;
  localparam int P  = 8;
  localparam int D  = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [4:0]    wr_data = '0;
  logic [3:0]    nibble_out;
  logic          blank_out;
  logic [ND-1:0] digit_an_n;
  logic          slot_start;

  int vectors     = 0;
  int miscompares = 0;

  // Model: edges since reset release plus the digit register contents.
  int unsigned n;
  logic [4:0]  mdig [ND];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NDIGITS (ND),
    .AW      (AW),
    .PRESCALE(P),
    .DEAD    (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .nibble_out(nibble_out),
    .blank_out (blank_out),
    .digit_an_n(digit_an_n),
    .slot_start(slot_start)
  );

  function automatic logic model_supp(int unsigned i);
`ifdef SEG7_SCAN_LZS_EN
    if (i == 0) return 1'b0;
    if (mdig[i][3:0] != 4'h0) return 1'b0;
    for (int unsigned j = i + 1; j < ND; j++)
      if (mdig[j][3:0] != 4'h0 && !mdig[j][4]) return 1'b0;
    return 1'b1;
`else
    return (i > ND);
`endif
  endfunction

  function automatic logic [ND+5:0] expected();
    int unsigned   c, p;
    logic          blank, ss;
    logic [ND-1:0] an;
    c     = n % P;
    p     = (n / P) % ND;
    ss    = (n != 0) && (c == 0);
    blank = (c < D) || mdig[p][4] || model_supp(p);
    an    = blank ? {ND{1'b1}} : ~(ND'(1) << p);
    return {ss, blank, an, mdig[p][3:0]};
  endfunction

  function automatic logic [ND+5:0] observed();
    return {slot_start, blank_out, digit_an_n, nibble_out};
  endfunction

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < ND; i++) mdig[i] = 5'h10;
  endtask

  task automatic step(input logic we, input logic [AW-1:0] a, input logic [4:0] d);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    n++;
    if (we && a < ND) mdig[a] = d;
    #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    vectors++;
    if (digit_an_n !== 4'b1111) begin
      miscompares++; $display("FAIL reset_an got=%b exp=1111", digit_an_n);
    end
    vectors++;
    if (blank_out !== 1'b1) begin
      miscompares++; $display("FAIL reset_blank got=%b exp=1", blank_out);
    end
    vectors++;
    if (nibble_out !== 4'h0) begin
      miscompares++; $display("FAIL reset_nibble got=%h exp=0", nibble_out);
    end
    vectors++;
    if (slot_start !== 1'b0) begin
      miscompares++; $display("FAIL reset_slot_start got=%b exp=0", slot_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int k = 0; k < 40; k++) begin
      step(1'b0, '0, '0);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL idle n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
  endtask

  task automatic test_pattern();
    for (int k = 0; k < 4 + 64; k++) begin
      if (k < 4) step(1'b1, AW'(k), 5'(k + 1));
      else       step(1'b0, '0, '0);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL pattern n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
  endtask

  task automatic test_midslot_write();
    int guard;
    step(1'b1, 3'd2, 5'h03);
    guard = 0;
    while (!(((n / P) % ND) == 2 && (n % P) == D + 1) && guard < 64) begin
      step(1'b0, '0, '0);
      guard++;
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL midslot_wait n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
    vectors++;
    if (guard >= 64 || digit_an_n !== 4'b1011) begin
      miscompares++;
      $display("FAIL midslot_lit got=%b exp=1011 guard=%0d", digit_an_n, guard);
    end
    step(1'b1, 3'd2, 5'h1A);
    vectors++;
    if ({digit_an_n, blank_out, nibble_out} !== {4'b1111, 1'b1, 4'hA}) begin
      miscompares++;
      $display("FAIL midslot_blank got=%b/%b/%h exp=1111/1/a", digit_an_n, blank_out, nibble_out);
    end
    for (int k = 0; k < 24; k++) begin
      step(1'b0, '0, '0);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL midslot_after n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
  endtask

  task automatic test_bad_addr();
    for (int k = 0; k < 40; k++) begin
      step(1'b1, AW'($urandom_range(ND, (1 << AW) - 1)), 5'($urandom_range(0, 31)));
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL bad_addr n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
  endtask

  task automatic test_lzs();
    int lit [ND];
    int exp_hi;
    step(1'b1, 3'd3, 5'h00);
    step(1'b1, 3'd2, 5'h00);
    step(1'b1, 3'd1, 5'h07);
    step(1'b1, 3'd0, 5'h00);
    for (int i = 0; i < ND; i++) lit[i] = 0;
    for (int k = 0; k < ND * P; k++) begin
      step(1'b0, '0, '0);
      for (int i = 0; i < ND; i++) if (digit_an_n[i] === 1'b0) lit[i]++;
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL lzs n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
`ifdef SEG7_SCAN_LZS_EN
    exp_hi = 0;
`else
    exp_hi = P - D;
`endif
    vectors++;
    if (lit[3] !== exp_hi || lit[2] !== exp_hi || lit[1] !== P - D || lit[0] !== P - D) begin
      miscompares++;
      $display("FAIL lzs_duty got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
               lit[3], lit[2], lit[1], lit[0], exp_hi, exp_hi, P - D, P - D);
    end
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] a;
    logic [4:0]    d;
    for (int k = 0; k < 400; k++) begin
      we   = ($urandom_range(0, 2) == 0);
      a    = AW'($urandom_range(0, (1 << AW) - 1));
      d    = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom_range(0, 15));
      d[4] = ($urandom_range(0, 3) == 0);
      step(we, a, d);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL random n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    for (int i = 0; i < ND; i++) step(1'b1, AW'(i), 5'(i + 5));
    guard = 0;
    while (digit_an_n === 4'b1111 && guard < 32) begin
      step(1'b0, '0, '0);
      guard++;
    end
    vectors++;
    if (guard >= 32) begin
      miscompares++; $display("FAIL async_setup got=%b exp=one_low", digit_an_n);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({digit_an_n, blank_out} !== {4'b1111, 1'b1}) begin
      miscompares++;
      $display("FAIL async_assert got=%b/%b exp=1111/1", digit_an_n, blank_out);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3 * P; k++) begin
      step(1'b0, '0, '0);
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL async_after n=%0d got=%b exp=%b", n, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_pattern();
    test_midslot_write();
    test_bad_addr();
    test_lzs();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. One shared nibble-to-segment decoder drives every digit, and this block time-slices it. The block holds one 4-bit value plus a blank flag per digit, written through a simple register port. It steps a digit pointer at a fixed slot rate and presents the selected nibble to the decoder. It drives active-low digit enables with a dead-time guard band so a digit never shows its neighbour's segments. The block sits between the host/control logic and the board's segment/anode pins.

## Interface
- NDIGITS, 4, number of digits scanned (2..8)
- AW, 2, write address width; must satisfy 2^AW >= NDIGITS
- PRESCALE, 50000, clock cycles per digit slot; must be > DEAD
- DEAD, 16, cycles at the start of each slot with all digits off (>= 1)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe, one digit register per asserted cycle
- wr_addr  in  AW  digit index; 0 = least significant (rightmost)
- wr_data  in  5  [3:0] nibble value, [4] blank flag (1 = digit dark)
- nibble_out  out  4  value fed to the shared hex-to-7-segment decoder
- blank_out  out  1  1 = segment drivers must be forced off this cycle
- digit_an_n  out  NDIGITS  active-low digit enables, at most one low
- slot_start  out  1  one-cycle pulse on the first cycle of every slot

## Operation
- State: slot counter cnt (0..PRESCALE-1), digit pointer ptr (0..NDIGITS-1), and digit registers dig[i] = {blank, value}.
- Each edge: if cnt == PRESCALE-1, cnt <- 0 and ptr <- (ptr == NDIGITS-1) ? 0 : ptr+1; otherwise cnt <- cnt+1.
- Phase DEAD (cnt < DEAD): digit_an_n all 1s and blank_out = 1.
- Phase SHOW (cnt >= DEAD): digit_an_n[ptr] = 0 unless the digit is effectively blank. Effectively blank means dig[ptr].blank, or suppressed under Configuration. If effectively blank, all enables stay 1 and blank_out = 1 for the whole slot.
- nibble_out = dig[ptr].value in both phases, so the decoder settles during DEAD.
- Write: on an edge with wr_en = 1 and wr_addr < NDIGITS, dig[wr_addr] <- wr_data. Writes with wr_addr >= NDIGITS are ignored and no other state changes.
- Writes never disturb cnt or ptr, and the scan runs free continuously.

## Timing
- All outputs are registers, computed from the next-state values of cnt, ptr and dig. Each output therefore always matches the current registered cnt/ptr, with no combinational glitch on the pins.
- Reset (async assert, state held while rst_n = 0):
  - cnt = 0, ptr = 0
  - every dig = {1, 4'h0}
  - digit_an_n = all 1s, blank_out = 1, nibble_out = 0, slot_start = 0
- First edge after rst_n rises: cnt = 1, slot_start = 0. The first slot_start pulse comes at the first wrap, PRESCALE edges after release.
- slot_start = 1 exactly when cnt == 0 after reset, i.e. once per PRESCALE cycles.
- A write at edge k is reflected on nibble_out/blank_out/digit_an_n after edge k (one cycle latency). This holds even when it targets the digit currently in SHOW; the change takes effect mid-slot.
- Full scan period = NDIGITS*PRESCALE cycles. Each digit's duty = (PRESCALE-DEAD)/(NDIGITS*PRESCALE).
- ptr wraps from NDIGITS-1 to 0 on the same edge that cnt wraps. There is no idle cycle between slots.
- Reset asserted mid-slot forces all enables high immediately (asynchronous), with no partial slot on release.

## Configuration
- SEG7_SCAN_LZS_EN defined: leading-zero suppression.
  - Digit i (i >= 1) is effectively blank when dig[i].value == 0 and every dig[j] with j > i also has value 0 or its blank flag set.
  - Digit 0 is never suppressed.
  - Suppression is evaluated combinationally from dig each cycle.
- Not defined: only the per-digit blank flag darkens a digit, and zeros display as "0".

## Test plan
- Reset, then release with NDIGITS=4, PRESCALE=8, DEAD=2, no writes -> digit_an_n stays 4'b1111 and blank_out = 1 indefinitely; the first slot_start comes 8 cycles after release, then every 8.
- Write dig0..3 = 5'h01, 5'h02, 5'h03, 5'h04 -> per slot: 2 cycles of 4'b1111, then 6 cycles with one low enable. Sequence is 4'b1110/nibble 1, 4'b1101/2, 4'b1011/3, 4'b0111/4, then repeats with period 32.
- During digit 2 SHOW, write wr_addr=2, wr_data=5'h1A -> on the next cycle digit_an_n = 4'b1111 and blank_out = 1; cnt/ptr timing unchanged.
- wr_addr=3'd5 on an NDIGITS=4, AW=3 build -> no register changes; scan sequence identical to the no-write reference.
- With SEG7_SCAN_LZS_EN, dig = {0,0,7,0} (digits 3..0) -> digits 3 and 2 dark, digit 1 shows 7, digit 0 shows 0. Without the macro, all four are lit.
- Assert rst_n low during a SHOW phase -> digit_an_n = 4'b1111 in the same cycle, no clock required. After release the scan restarts at ptr 0 and all digits are blank.
